// File: rtl/al_accel_obuf_ctrl.sv
// Output-buffer sequencer: accumulates NUM_PASS passes of partial sums into
// NUM_WORDS obuf entries per tile, then drains the finished words to the
// writeback stream with valid/ready handshaking.
module al_accel_obuf_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PASS_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W:0]     cfg_num_words,
    input  logic [PASS_W-1:0]   cfg_num_pass,
    input  logic                psum_valid,
    output logic                psum_ready,
    output logic                obuf_enb,
    output logic                obuf_ld_wrn,
    output logic                obuf_first,
    output logic [ADDR_W-1:0]   obuf_addr,
    input  logic [DATA_W-1:0]   obuf_do,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_last,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NW_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [PASS_W-1:0]   pass_q;
    logic [NW_W-1:0]     num_words_q;
    logic [PASS_W-1:0]   num_pass_q;

    logic                cfg_ok_c;
    logic [ADDR_W-1:0]   last_addr_c;
    logic [PASS_W-1:0]   last_pass_c;
    logic                at_last_addr_c;

    // Tile configuration is usable only with 1..DEPTH words and at least one pass
    assign cfg_ok_c = (cfg_num_words != '0)
                   && (cfg_num_words <= NW_W'(DEPTH))
                   && (cfg_num_pass != '0);

    // Last-word compare is done on ADDR_W bits so a full-depth tile wraps cleanly
    assign last_addr_c    = ADDR_W'(num_words_q - NW_W'(1));
    assign last_pass_c    = num_pass_q - PASS_W'(1);
    assign at_last_addr_c = (addr_q == last_addr_c);

    // Sequencer: state, address/pass counters, latched config and cfg_err pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pass_q      <= '0;
            num_words_q <= '0;
            num_pass_q  <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (cfg_ok_c) begin
                            num_words_q <= cfg_num_words;
                            num_pass_q  <= cfg_num_pass;
                            addr_q      <= '0;
                            pass_q      <= '0;
                            state_q     <= S_ACCUM;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (abort) begin
                        addr_q  <= '0;
                        pass_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (psum_valid) begin
                        if (at_last_addr_c) begin
                            addr_q <= '0;
                            if (pass_q == last_pass_c) begin
                                pass_q  <= '0;
                                state_q <= S_DRAIN;
                            end else begin
                                pass_q <= pass_q + PASS_W'(1);
                            end
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        addr_q  <= '0;
                        pass_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (wb_ready) begin
                        if (at_last_addr_c) begin
                            addr_q  <= '0;
                            state_q <= S_DONE;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    addr_q  <= '0;
                    pass_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    addr_q  <= '0;
                    pass_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state registers; ld_wrn and wb_data follow their inputs
    assign psum_ready  = (state_q == S_ACCUM);
    assign obuf_enb    = (state_q == S_ACCUM) || (state_q == S_DRAIN);
    assign obuf_ld_wrn = (state_q == S_ACCUM) && psum_valid;
    assign obuf_first  = (state_q == S_ACCUM) && (pass_q == '0);
    assign obuf_addr   = addr_q;
    assign wb_valid    = (state_q == S_DRAIN);
    assign wb_last     = (state_q == S_DRAIN) && at_last_addr_c;
    assign wb_data     = (state_q == S_DRAIN) ? obuf_do : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule
